// File: rtl/mem_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mem_host_bridge
//  Purpose  : Upstream command stage for memory_system. Queues read/write
//             commands in a small FIFO, issues them one at a time over the
//             host_req/host_ack four-phase handshake, and returns results on
//             a valid/ready response channel with a timeout error flag.
//  Options  : MHB_WRITE_RSP_EN - when defined, successful writes also return
//             a response (rsp_wr=1, rsp_rdata=0). When undefined, only reads
//             and timed-out commands produce responses.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_host_bridge #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_wr,
    output logic              rsp_err,
    output logic              host_req,
    output logic              host_wr_en,
    output logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_wdata,
    input  logic [DATA_W-1:0] host_rdata,
    input  logic              host_ack,
    output logic              busy,
    output logic [15:0]       err_cnt
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [15:0]        c_ERR_MAX  = 16'hFFFF;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_RSP  = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    // Command FIFO storage and bookkeeping
    logic [DEPTH-1:0]   r_fifo_wr;
    logic [ADDR_W-1:0]  r_fifo_addr  [DEPTH];
    logic [DATA_W-1:0]  r_fifo_wdata [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    // Sequencer state and registered outputs
    logic [1:0]         r_state;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_host_req;
    logic               r_host_wr_en;
    logic [ADDR_W-1:0]  r_host_addr;
    logic [DATA_W-1:0]  r_host_wdata;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_wr;
    logic               r_rsp_err;
    logic [15:0]        r_err_cnt;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == c_FULL);
    assign w_push = cmd_valid && !w_full;
    // A new request may only start once the previous ack has fully dropped.
    assign w_pop  = (r_state == c_ST_IDLE) && (r_count != '0) && !host_ack;

    assign cmd_ready  = !w_full;
    assign busy       = (r_count != '0) || (r_state != c_ST_IDLE);
    assign host_req   = r_host_req;
    assign host_wr_en = r_host_wr_en;
    assign host_addr  = r_host_addr;
    assign host_wdata = r_host_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_err    = r_rsp_err;
    assign err_cnt    = r_err_cnt;

    // Command FIFO: write on push, advance read pointer on pop, both may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_fifo_wr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i]  <= '0;
                r_fifo_wdata[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_wr[r_wptr]    <= cmd_wr;
                r_fifo_addr[r_wptr]  <= cmd_addr;
                r_fifo_wdata[r_wptr] <= cmd_wdata;
                r_wptr               <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Host handshake sequencer: issue, wait for ack or timeout, return response, gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_tmo        <= '0;
            r_host_req   <= 1'b0;
            r_host_wr_en <= 1'b0;
            r_host_addr  <= '0;
            r_host_wdata <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_wr     <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_host_req   <= 1'b1;
                        r_host_wr_en <= r_fifo_wr[r_rptr];
                        r_host_addr  <= r_fifo_addr[r_rptr];
                        r_host_wdata <= r_fifo_wdata[r_rptr];
                        r_tmo        <= '0;
                        r_state      <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (host_ack) begin
                        // An ack on the same edge as the last timeout cycle still counts as success.
                        r_host_req <= 1'b0;
`ifdef MHB_WRITE_RSP_EN
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_host_wr_en ? '0 : host_rdata;
                        r_rsp_wr    <= r_host_wr_en;
                        r_rsp_err   <= 1'b0;
                        r_state     <= c_ST_RSP;
`else
                        if (r_host_wr_en) begin
                            // Successful writes are silent in this build.
                            r_state <= c_ST_GAP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= host_rdata;
                            r_rsp_wr    <= 1'b0;
                            r_rsp_err   <= 1'b0;
                            r_state     <= c_ST_RSP;
                        end
`endif
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_host_req  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_wr    <= r_host_wr_en;
                        r_rsp_err   <= 1'b1;
                        if (r_err_cnt != c_ERR_MAX) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_state <= c_ST_RSP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    // Hold off until a late or stuck ack has been released.
                    if (!host_ack) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
